// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter. An NCO phase accumulator sets the bit timing.
// Define UART_TX_PARITY_EN to send 8-E-1 frames instead (adds an even-parity bit).
module uart_tx #(
    parameter int unsigned clk_hz    = 50_000_000,
    parameter int unsigned baud      = 115_200,
    parameter int unsigned ACC_width = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    // Rounded phase increment. It must be in the range 1 .. 2^ACC_width-1.
    localparam logic [63:0] INCR64 =
        ((64'(baud) << ACC_width) + 64'(clk_hz / 2)) / 64'(clk_hz);
    localparam logic [ACC_width:0] INCR = INCR64[ACC_width:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [ACC_width-1:0] phase_reg, phase_next;
    logic [7:0]           shreg_reg, shreg_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;
    logic [ACC_width:0]   sum;
    logic                 tick;

    assign sum  = {1'b0, phase_reg} + INCR;
    assign tick = sum[ACC_width];

`ifdef UART_TX_PARITY_EN
    genvar gi;
    logic [8:0] par_chain;
    logic       par_reg, par_next;

    assign par_chain[0] = 1'b0;
    for (gi = 0; gi < 8; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ data_i[gi];
    end
`endif

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        shreg_next   = shreg_reg;
        bit_idx_next = bit_idx_reg;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next     = par_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                phase_next = '0;
                if (valid_i) begin
                    shreg_next   = data_i;
                    bit_idx_next = 3'd0;
                    state_next   = S_START;
`ifdef UART_TX_PARITY_EN
                    par_next     = par_chain[8];
`endif
                end
            end
            S_START: begin
                phase_next = sum[ACC_width-1:0];
                if (tick) state_next = S_DATA;
            end
            S_DATA: begin
                phase_next = sum[ACC_width-1:0];
                if (tick) begin
                    shreg_next   = {1'b0, shreg_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                phase_next = sum[ACC_width-1:0];
                if (tick) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                phase_next = sum[ACC_width-1:0];
                if (tick) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // The line level is decoded from the next state, so tx_o stays a plain register.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = par_reg;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            phase_reg   <= '0;
            shreg_reg   <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            shreg_reg   <= shreg_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
            done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    assign ready_o = (state_reg == S_IDLE);
    assign busy_o  = (state_reg != S_IDLE);
    assign tx_o    = tx_reg;
    assign done_o  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 50 MHz / 115200 baud (about 434 clock cycles per bit).
// It decodes the serial line by sampling each bit near its midpoint.
module tb_uart_tx;

    localparam int BIT  = 434;
    localparam int HALF = 217;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int DONE_EXP   = 4775;
    localparam int SEG_CHECKS = 8;
`else
    localparam int FRAME_BITS = 10;
    localparam int DONE_EXP   = 4341;
    localparam int SEG_CHECKS = 9;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o, tx_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0] rb, rb2;
    logic       rp, rs, rok, rp2, rs2, rok2;
    int         seg_len [12];
    int         d0, lows, gap, dn, dtime, seg, len, wt;
    logic       prev;

    uart_tx #(.clk_hz(50_000_000), .baud(115_200), .ACC_width(24)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .tx_o   (tx_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_o === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        data_i  = d;
        valid_i = 1'b1;
        while (ready_o !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (ready_o !== 1'b1) begin
            check("send_accept_timeout", 32'd0, 32'd1);
            valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic rx_frame(output logic [7:0] b, output logic par, output logic stop,
                            output logic ok);
        int n = 0;
        b = 8'h00; par = 1'b0; stop = 1'b0; ok = 1'b0;
        while (tx_o !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (tx_o !== 1'b0) return;
        repeat (HALF) @(negedge clk);
        if (tx_o !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = tx_o;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BIT) @(negedge clk);
        par = tx_o;
`endif
        repeat (BIT) @(negedge clk);
        stop = tx_o;
        ok   = 1'b1;
    endtask

    task automatic watch_idle(input int cycles, output int low_cnt);
        low_cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_o !== 1'b1) low_cnt++;
        end
    endtask

    initial begin
        // Test 1: reset values and a quiet idle line
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        rst = 1'b0;
        d0 = done_cnt;
        watch_idle(100, lows);
        check("idle_tx_low_cycles", lows, 0);
        check("idle_done_pulses", done_cnt - d0, 0);
        check("idle_ready", ready_o, 1);
        check("idle_busy", busy_o, 0);

        // Test 2: single 0x55 frame with bit-period measurement
        send(8'h55);
        check("t2_busy", busy_o, 1);
        check("t2_ready", ready_o, 0);
        fork
            rx_frame(rb, rp, rs, rok);
            begin
                prev = tx_o; len = 1; seg = 0; dn = 0; dtime = 0;
                for (int t = 1; t <= FRAME_BITS * BIT + 200; t++) begin
                    @(negedge clk);
                    if (done_o === 1'b1) begin
                        dn++;
                        dtime = t;
                    end
                    if (tx_o !== prev) begin
                        if (seg < 12) seg_len[seg] = len;
                        seg++;
                        len  = 1;
                        prev = tx_o;
                    end else begin
                        len++;
                    end
                end
            end
        join
        $display("frame: sent 0x55 decoded 0x%02h stop %0d", rb, rs);
        check("t2_byte", rb, 8'h55);
        check("t2_stop", rs, 1);
        check("t2_rx_ok", rok, 1);
`ifdef UART_TX_PARITY_EN
        check("t2_parity", rp, 0);
`endif
        check("t2_seg_count_min", seg >= SEG_CHECKS, 1);
        for (int i = 0; i < SEG_CHECKS; i++)
            check($sformatf("t2_bit%0d_len_in_433_435", i),
                  seg_len[i] >= 433 && seg_len[i] <= 435, 1);
        check("t2_done_pulses", dn, 1);
        check("t2_done_time_near", dtime >= DONE_EXP - 2 && dtime <= DONE_EXP + 2, 1);

        // Test 3: back-to-back frames with valid_i held high
        d0 = done_cnt;
        fork
            begin
                send(8'hA3);
                send(8'h0F);
            end
            begin
                rx_frame(rb, rp, rs, rok);
                rx_frame(rb2, rp2, rs2, rok2);
            end
            begin
                wt = 0;
                while (done_o !== 1'b1 && wt < 12000) begin
                    @(negedge clk);
                    wt++;
                end
                gap = 0;
                while (tx_o === 1'b1 && gap < 10) begin
                    @(negedge clk);
                    gap++;
                end
            end
        join
        repeat (400) @(negedge clk);
        $display("frame: sent 0xa3 decoded 0x%02h", rb);
        $display("frame: sent 0x0f decoded 0x%02h", rb2);
        check("t3_byte0", rb, 8'hA3);
        check("t3_byte1", rb2, 8'h0F);
        check("t3_stop0", rs, 1);
        check("t3_stop1", rs2, 1);
        check("t3_gap_cycles", gap, 1);
        check("t3_done_pulses", done_cnt - d0, 2);
`ifdef UART_TX_PARITY_EN
        check("t3_parity0", rp, 0);
        check("t3_parity1", rp2, 0);
`endif

        // Test 4: valid_i pulse mid-frame is ignored
        d0 = done_cnt;
        send(8'h00);
        fork
            rx_frame(rb, rp, rs, rok);
            begin
                repeat (1000) @(negedge clk);
                data_i  = 8'hFF;
                valid_i = 1'b1;
                check("t4_ready_midframe", ready_o, 0);
                @(negedge clk);
                valid_i = 1'b0;
            end
        join
        watch_idle(5000, lows);
        $display("frame: sent 0x00 decoded 0x%02h", rb);
        check("t4_byte", rb, 8'h00);
        check("t4_stop", rs, 1);
        check("t4_no_second_frame", lows, 0);
        check("t4_done_pulses", done_cnt - d0, 1);

        // Test 5: reset during data bit 3 aborts the frame
        d0 = done_cnt;
        send(8'h3C);
        repeat (1950) @(negedge clk);
        check("t5_busy_before_rst", busy_o, 1);
        check("t5_tx_bit3", tx_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_tx_after_rst", tx_o, 1);
        check("t5_ready_after_rst", ready_o, 1);
        check("t5_busy_after_rst", busy_o, 0);
        rst = 1'b0;
        watch_idle(5000, lows);
        check("t5_line_idle", lows, 0);
        check("t5_no_done", done_cnt - d0, 0);
        send(8'h81);
        rx_frame(rb, rp, rs, rok);
        $display("frame: sent 0x81 decoded 0x%02h", rb);
        check("t5_byte_after_rst", rb, 8'h81);
        check("t5_stop_after_rst", rs, 1);

`ifdef UART_TX_PARITY_EN
        // Test 6: even parity bit values
        repeat (400) @(negedge clk);
        send(8'h07);
        rx_frame(rb, rp, rs, rok);
        $display("frame: sent 0x07 decoded 0x%02h parity %0d", rb, rp);
        check("t6_byte_07", rb, 8'h07);
        check("t6_parity_07", rp, 1);
        check("t6_stop_07", rs, 1);
        repeat (400) @(negedge clk);
        send(8'h55);
        rx_frame(rb, rp, rs, rok);
        $display("frame: sent 0x55 decoded 0x%02h parity %0d", rb, rp);
        check("t6_byte_55", rb, 8'h55);
        check("t6_parity_55", rp, 0);
        check("t6_stop_55", rs, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
